pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits, min 1.
REQ-002 Parameter CTRL_W, default 10: width of the control field, held in out_data[WIDTH-1 -: CTRL_W]; CTRL_W <= WIDTH.
REQ-003 Parameter CNT_W, default 16: stall counter width.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 in_valid  in  1  producer offers in_data.
REQ-008 in_data  in  WIDTH  payload: packed control, operands, PC, register indices.
REQ-009 in_ready  out  1  stage accepts in_data this cycle.
REQ-010 out_valid  out  1  out_data holds a valid instruction.
REQ-011 out_data  out  WIDTH  oldest held payload.
REQ-012 out_ready  in  1  consumer takes out_data this cycle.
REQ-013 hit  in  1  cache hit; logic 0 freezes the stage; 1, X or Z enables it.
REQ-014 flush  in  1  synchronous bubble insertion.
REQ-015 occupancy  out  2  number of held entries, 0..2.
REQ-016 stall_cnt  out  CNT_W  saturating count of stalled cycles.

Function
REQ-017 An input transfer occurs when in_valid && in_ready.
REQ-018 An output transfer occurs when out_valid && out_ready && hit!==0 && !flush.
REQ-019 While hit==0: no input or output transfer; all entries, occupancy and out_data hold; in_ready=0.
REQ-020 Base mode has one entry.
- in_ready = hit!==0 && !flush && (!out_valid || out_ready).
- Simultaneous input and output transfer replaces the entry; out_valid stays 1.
REQ-021 Latency is 1 cycle: data accepted at edge N appears on out_data after edge N.
REQ-022 After an output transfer with no input transfer: out_valid=0; out_data keeps its last value.
REQ-023 flush=1 at an edge:
- Clears all entries; out_valid=0; occupancy=0.
- Zeroes the control field of out_data.
- Overrides hit, in_valid and out_ready.
- in_ready=0 during the flush cycle.
REQ-024 Payloads leave in acceptance order; no payload is duplicated or dropped, except by flush or rst.
REQ-025 stall_cnt increments each cycle where (out_valid && !out_ready) || hit==0.
- Saturates at all-ones.
- Cleared only by rst; flush does not clear it.
REQ-026 occupancy always equals the number of accepted minus transferred entries since the last flush or rst.

Reset
REQ-027 rst=1 immediately forces:
- out_valid=0, out_data=0, occupancy=0, stall_cnt=0.
- Skid entry empty.
- in_ready=0 while rst is asserted.
REQ-028 rst asserted mid-transfer discards all held payloads.
REQ-029 The first input transfer is possible at the first rising edge after rst deasserts.

Configuration
REQ-030 Macro PIPE_SKID_EN defined: a second skid entry is present.
- in_ready = hit!==0 && !flush && occupancy<2, with no combinational path from out_ready.
- An input transfer while the main entry is held and not transferred goes to the skid entry.
- The skid entry moves to the main entry on the next output transfer.
- Sustained throughput is 1 per cycle.
REQ-031 Macro PIPE_SKID_EN undefined:
- Behaviour per REQ-020; occupancy never exceeds 1.
- occupancy[1] is tied to 0.

Verification
REQ-032 Stream 0x11, 0x22, 0x33 with out_ready=1 and hit=1 -> out_data equals 0x11, 0x22, 0x33 on consecutive cycles, each 1 cycle after acceptance.
REQ-033 Hold 0xAA, then drive hit=0 for 3 cycles with in_valid=1 -> out_data stays 0xAA, in_ready=0, stall_cnt=3; hit=1 resumes without loss.
REQ-034 out_valid=1 with control field 0x3FF, then flush=1 together with in_valid=1 -> next cycle out_valid=0, control field=0, occupancy=0, and the input is not accepted.
REQ-035 PIPE_SKID_EN: out_ready=0, then accept 0x01 and 0x02 -> occupancy=2, in_ready=0; raise out_ready -> 0x01 then 0x02 are delivered.
REQ-036 Assert rst asynchronously between clock edges while occupancy=1 and stall_cnt=5 -> all outputs are immediately 0; first transfer occurs on the first edge after release.
REQ-037 CNT_W=2: hold a stall for 6 cycles -> stall_cnt stops at 3.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with hit-gated freeze, flush and a stall counter.
// Define PIPE_SKID_EN to add a second skid entry, which removes the out_ready -> in_ready path.
module pipe_stage_reg #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 10,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             hit,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             hit_en;
  logic             in_xfer;
  logic             out_xfer;
  logic             stall_inc;
  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // An unknown or floating hit must not freeze the stage; only a solid 0 does.
  assign hit_en   = (hit !== 1'b0);
  assign out_xfer = main_valid_q && out_ready && hit_en && !flush;
  assign in_xfer  = in_valid && in_ready;

`ifdef PIPE_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;

  assign in_ready  = !rst && hit_en && !flush && !skid_valid_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d                   = 1'b0;
      skid_valid_d                   = 1'b0;
      main_data_d[WIDTH-1 -: CTRL_W] = '0;
    end else if (out_xfer) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        main_data_d = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      if (main_valid_q) begin
        skid_data_d  = in_data;
        skid_valid_d = 1'b1;
      end else begin
        main_data_d  = in_data;
        main_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  assign in_ready  = !rst && hit_en && !flush && (!main_valid_q || out_ready);
  assign occupancy = {1'b0, main_valid_q};

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    if (flush) begin
      main_valid_d                   = 1'b0;
      main_data_d[WIDTH-1 -: CTRL_W] = '0;
    end else if (in_xfer) begin
      main_data_d  = in_data;
      main_valid_d = 1'b1;
    end else if (out_xfer) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  assign stall_inc   = (main_valid_q && !out_ready) || !hit_en;
  assign stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed plus randomized bench for pipe_stage_reg, checked against a queue-based model.
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_EN
  localparam int Cap = 2;
`else
  localparam int Cap = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, hit, flush;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  // Small instance used only to observe counter saturation.
  logic       sat_hit;
  logic       sat_in_ready, sat_out_valid;
  logic [7:0] sat_out_data;
  logic [1:0] sat_occ;
  logic [1:0] sat_stall;

  int ncmp = 0;
  int nerr = 0;

  logic [31:0] q[$];
  logic [31:0] shown;
  int          m_stall;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .hit(hit),
    .flush(flush), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.WIDTH(8), .CTRL_W(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(1'b0), .in_data(8'h00), .in_ready(sat_in_ready),
    .out_valid(sat_out_valid), .out_data(sat_out_data), .out_ready(1'b0), .hit(sat_hit),
    .flush(1'b0), .occupancy(sat_occ), .stall_cnt(sat_stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    shown   = '0;
    m_stall = 0;
  endtask

  // One clock: drive at negedge, check in_ready, clock, update model, check state.
  task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic h,
                      input logic fl);
    logic exp_ir, in_x, out_x;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    hit       = h;
    flush     = fl;
    #1;
    if (Cap == 2) exp_ir = h && !fl && (q.size() < 2);
    else          exp_ir = h && !fl && (q.size() == 0 || ordy);
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
    in_x  = iv && exp_ir;
    out_x = (q.size() > 0) && ordy && h && !fl;
    if (((q.size() > 0) && !ordy) || !h) m_stall = (m_stall < 16'hFFFF) ? m_stall + 1 : m_stall;
    @(posedge clk);
    if (fl) begin
      q.delete();
      shown[31:22] = '0;
    end else begin
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back(d);
    end
    if (q.size() > 0) shown = q[0];
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    chk("out_data", {32'd0, out_data}, {32'd0, shown});
    chk("occupancy", {62'd0, occupancy}, 64'(q.size()));
    chk("stall_cnt", {48'd0, stall_cnt}, 64'(m_stall));
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_data = '0; out_ready = 0; hit = 1; flush = 0; sat_hit = 1;
    model_clear();
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Async reset between edges with one entry held and stall_cnt at 5.
    step(1, 32'h0000_00C5, 0, 1, 0);
    repeat (5) step(0, 32'h0, 0, 1, 0);
    chk("pre_rst_stall", {48'd0, stall_cnt}, 64'd5);
    chk("pre_rst_occ", {62'd0, occupancy}, 64'd1);
    #2 rst = 1'b1;
    in_valid = 1; hit = 1; out_ready = 1;
    #1;
    model_clear();
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_out_data", {32'd0, out_data}, 64'd0);
    chk("arst_occ", {62'd0, occupancy}, 64'd0);
    chk("arst_stall", {48'd0, stall_cnt}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk) rst = 1'b0;
    step(1, 32'h0000_0077, 1, 1, 0);
    chk("first_after_rst", {32'd0, out_data}, 64'h77);
    step(0, 32'h0, 1, 1, 0);

    // Back-to-back stream, one cycle latency.
    step(1, 32'h11, 1, 1, 0);
    chk("stream0", {32'd0, out_data}, 64'h11);
    step(1, 32'h22, 1, 1, 0);
    chk("stream1", {32'd0, out_data}, 64'h22);
    step(1, 32'h33, 1, 1, 0);
    chk("stream2", {32'd0, out_data}, 64'h33);
    step(0, 32'h0, 1, 1, 0);
    chk("drained_keeps", {32'd0, out_data}, 64'h33);

    // Freeze with hit=0.
    step(1, 32'hAA, 0, 1, 0);
    repeat (3) step(1, 32'hBB, 0, 0, 0);
    chk("freeze_data", {32'd0, out_data}, 64'hAA);
    chk("freeze_stall", {48'd0, stall_cnt}, 64'd3);
    step(1, 32'hBB, 1, 1, 0);
    step(0, 32'h0, 1, 1, 0);

    // Flush overrides a concurrent input.
    step(1, 32'hFFC0_0123, 0, 1, 0);
    step(1, 32'h0000_0456, 1, 1, 1);
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_ctrl", {54'd0, out_data[31:22]}, 64'd0);
    chk("flush_occ", {62'd0, occupancy}, 64'd0);

`ifdef PIPE_SKID_EN
    step(1, 32'h01, 0, 1, 0);
    step(1, 32'h02, 0, 1, 0);
    chk("skid_occ", {62'd0, occupancy}, 64'd2);
    step(1, 32'h03, 1, 1, 0);
    chk("skid_first", {32'd0, out_data}, 64'h02);
    step(0, 32'h0, 1, 1, 0);
`endif

    // Saturation of a 2-bit stall counter.
    sat_hit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(0, 32'h0, 1, 1, 0);
      chk("sat_stall", {62'd0, sat_stall}, (i < 3) ? 64'(i + 1) : 64'd3);
    end
    sat_hit = 1'b1;

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 8) != 0,
           ($urandom % 32) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
